// File: rtl/core_seq_ctl.sv
`default_nettype none
// ============================================================================
// Module   : core_seq_ctl
// Brief    : Multi-cycle FETCH/EXEC/MEM/WB instruction sequencer for hxd32.
//            Gates decoder write enables, handshakes with instruction and
//            data RAM, and provides run/halt control, a retired-instruction
//            counter and a data-RAM timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module core_seq_ctl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic             halt_req_i,
    input  logic             iram_rd_valid_i,
    input  logic             inst_load_i,
    input  logic             inst_store_i,
    input  logic             inst_illegal_i,
    input  logic             dec_rd_wr_en_i,
    input  logic             dram_ready_i,
    output logic             iram_rd_en_o,
    output logic             inst_latch_en_o,
    output logic             pc_wr_en_o,
    output logic             rd_wr_en_o,
    output logic             dram_rd_en_o,
    output logic             dram_wr_en_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [1:0]       err_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    state_t           state;
    state_t           state_nxt;
    logic             halt_pend;
    logic [1:0]       err;
    logic [CNT_W-1:0] instret;
    logic             inst_bad;
    logic             mem_entry;
    logic             halt_entry;
    logic             to_hit;
    logic             set_err_ill;
    logic             set_err_to;
    logic             clr_err;

    // A load that is also a store is treated exactly like an unsupported opcode.
    assign inst_bad   = inst_illegal_i | (inst_load_i & inst_store_i);
    assign mem_entry  = (state_nxt == MEM)  && (state != MEM);
    assign halt_entry = (state_nxt == HALT) && (state != HALT);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Mealy output enables; outputs derive from the
    // current state so an async reset drops every enable immediately.
    always_comb begin
        state_nxt       = state;
        iram_rd_en_o    = 1'b0;
        inst_latch_en_o = 1'b0;
        pc_wr_en_o      = 1'b0;
        rd_wr_en_o      = 1'b0;
        dram_rd_en_o    = 1'b0;
        dram_wr_en_o    = 1'b0;
        busy_o          = 1'b0;
        halted_o        = 1'b0;
        set_err_ill     = 1'b0;
        set_err_to      = 1'b0;
        clr_err         = 1'b0;
        case (state)
            IDLE: begin
                if (run_i) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy_o       = 1'b1;
                iram_rd_en_o = 1'b1;
                // An arriving instruction is always taken before a pending halt.
                if (iram_rd_valid_i) begin
                    inst_latch_en_o = 1'b1;
                    state_nxt       = EXEC;
                end else if (halt_pend) begin
                    state_nxt = HALT;
                end
            end
            EXEC: begin
                busy_o = 1'b1;
                if (inst_bad) begin
                    set_err_ill = 1'b1;
                    state_nxt   = HALT;
                end else if (inst_load_i || inst_store_i) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                busy_o       = 1'b1;
                dram_rd_en_o = inst_load_i;
                dram_wr_en_o = inst_store_i & ~inst_load_i;
                if (dram_ready_i) begin
                    state_nxt = WB;
                end else if (to_hit) begin
                    set_err_to = 1'b1;
                    state_nxt  = HALT;
                end
            end
            WB: begin
                busy_o     = 1'b1;
                pc_wr_en_o = 1'b1;
                rd_wr_en_o = dec_rd_wr_en_i & ~inst_store_i;
                if (halt_pend || halt_req_i) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = FETCH;
                end
            end
            HALT: begin
                halted_o = 1'b1;
                if (run_i && !halt_req_i) begin
                    clr_err   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Halt request is remembered until the sequencer actually reaches HALT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            halt_pend <= 1'b0;
        end else if (halt_entry) begin
            halt_pend <= 1'b0;
        end else if (halt_req_i) begin
            halt_pend <= 1'b1;
        end
    end

    // Sticky error code, cleared only when resuming from HALT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err <= ERR_NONE;
        end else if (set_err_ill) begin
            err <= ERR_ILLEGAL;
        end else if (set_err_to) begin
            err <= ERR_TIMEOUT;
        end else if (clr_err) begin
            err <= ERR_NONE;
        end
    end

    // Retired-instruction counter; one retirement per WB cycle, wraps freely.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instret <= '0;
        end else if (state == WB) begin
            instret <= instret + CNT_W'(1);
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int              TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

            logic [TO_W-1:0] to_cnt;

            // MEM wait counter: restarts on MEM entry, counts unanswered cycles.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    to_cnt <= '0;
                end else if (mem_entry) begin
                    to_cnt <= '0;
                end else if ((state == MEM) && !dram_ready_i && (to_cnt != TO_LAST)) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end

            assign to_hit = (state == MEM) && !dram_ready_i && (to_cnt == TO_LAST);
        end else begin : g_no_timeout
            assign to_hit = 1'b0;
        end
    endgenerate

    assign err_o     = err;
    assign state_o   = state;
    assign instret_o = instret;

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_seq_ctl
// Brief    : Self-checking bench for core_seq_ctl with a retirement scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_seq_ctl;

    localparam int CNT_W  = 5;
    localparam int MEM_TO = 4;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             run_i, halt_req_i, iram_rd_valid_i;
    logic             inst_load_i, inst_store_i, inst_illegal_i;
    logic             dec_rd_wr_en_i, dram_ready_i;
    logic             iram_rd_en_o, inst_latch_en_o, pc_wr_en_o, rd_wr_en_o;
    logic             dram_rd_en_o, dram_wr_en_o, busy_o, halted_o;
    logic [1:0]       err_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instret_o;

    typedef struct packed {
        logic             rd;
        logic [CNT_W-1:0] cnt;
    } sb_t;

    sb_t              sb_q[$];
    logic [CNT_W-1:0] model_cnt;
    int               n_checks = 0;
    int               n_errors = 0;

    core_seq_ctl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i), .halt_req_i(halt_req_i),
        .iram_rd_valid_i(iram_rd_valid_i), .inst_load_i(inst_load_i),
        .inst_store_i(inst_store_i), .inst_illegal_i(inst_illegal_i),
        .dec_rd_wr_en_i(dec_rd_wr_en_i), .dram_ready_i(dram_ready_i),
        .iram_rd_en_o(iram_rd_en_o), .inst_latch_en_o(inst_latch_en_o),
        .pc_wr_en_o(pc_wr_en_o), .rd_wr_en_o(rd_wr_en_o),
        .dram_rd_en_o(dram_rd_en_o), .dram_wr_en_o(dram_wr_en_o),
        .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o),
        .state_o(state_o), .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [5:0] enables();
        return {iram_rd_en_o, inst_latch_en_o, pc_wr_en_o, rd_wr_en_o, dram_rd_en_o, dram_wr_en_o};
    endfunction

    // Scoreboard consumer: every WB cycle retires the oldest issued instruction.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (pc_wr_en_o || rd_wr_en_o)
                check("wb_only", {29'd0, state_o}, 32'd4);
            if (dram_rd_en_o && dram_wr_en_o)
                check("dram_onehot", 32'd1, 32'd0);
            if (pc_wr_en_o) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_wb", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("wb_rd_wr_en", {31'd0, rd_wr_en_o}, {31'd0, e.rd});
                    check("wb_instret", {27'd0, instret_o}, {27'd0, e.cnt});
                end
            end
        end
    end

    // Resume from IDLE or HALT with a one-cycle run pulse.
    task automatic resume();
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
        #1;
        check("resume_state", {29'd0, state_o}, 32'd1);
        check("resume_err", {30'd0, err_o}, 32'd0);
    endtask

    // Issue one instruction starting in FETCH. wait_n < 0 means data RAM never answers.
    task automatic exec_inst(input bit ld, input bit st, input bit ill, input bit rdw,
                             input int wait_n, input bit halt_f, input bit halt_e,
                             input bit exp_halt);
        bit bad;
        int n;
        bad = ill | (ld & st);
        inst_load_i     = ld;
        inst_store_i    = st;
        inst_illegal_i  = ill;
        dec_rd_wr_en_i  = rdw;
        iram_rd_valid_i = 1'b1;
        halt_req_i      = halt_f;
        if (!bad && wait_n >= 0) begin
            sb_q.push_back('{rd: rdw & ~st, cnt: model_cnt});
            model_cnt = model_cnt + 1'b1;
        end
        #1;
        check("fetch_state", {29'd0, state_o}, 32'd1);
        check("fetch_en", {26'd0, enables()}, 32'b110000);
        tick();
        iram_rd_valid_i = 1'b0;
        halt_req_i      = halt_e;
        #1;
        check("exec_state", {29'd0, state_o}, 32'd2);
        check("exec_en", {26'd0, enables()}, 32'd0);
        tick();
        halt_req_i = 1'b0;
        if (bad) begin
            #1;
            check("ill_state", {29'd0, state_o}, 32'd5);
            check("ill_err", {30'd0, err_o}, 32'd1);
            check("ill_en", {26'd0, enables()}, 32'd0);
            return;
        end
        if (ld || st) begin
            n = (wait_n < 0) ? MEM_TO : wait_n + 1;
            for (int k = 0; k < n; k++) begin
                dram_ready_i = (wait_n >= 0) && (k == wait_n);
                #1;
                check("mem_state", {29'd0, state_o}, 32'd3);
                check("mem_rd_en", {31'd0, dram_rd_en_o}, {31'd0, ld});
                check("mem_wr_en", {31'd0, dram_wr_en_o}, {31'd0, st});
                tick();
            end
            dram_ready_i = 1'b0;
            if (wait_n < 0) begin
                #1;
                check("to_state", {29'd0, state_o}, 32'd5);
                check("to_err", {30'd0, err_o}, 32'd2);
                check("to_en", {26'd0, enables()}, 32'd0);
                check("to_instret", {27'd0, instret_o}, {27'd0, model_cnt});
                return;
            end
        end
        #1;
        check("wb_state", {29'd0, state_o}, 32'd4);
        check("wb_pc_en", {31'd0, pc_wr_en_o}, 32'd1);
        tick();
        #1;
        check("post_wb_state", {29'd0, state_o}, exp_halt ? 32'd5 : 32'd1);
        if (exp_halt) begin
            check("post_wb_halted", {31'd0, halted_o}, 32'd1);
            check("post_wb_busy", {31'd0, busy_o}, 32'd0);
        end
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0; run_i = 1'b0; halt_req_i = 1'b0; iram_rd_valid_i = 1'b0;
        inst_load_i = 1'b0; inst_store_i = 1'b0; inst_illegal_i = 1'b0;
        dec_rd_wr_en_i = 1'b0; dram_ready_i = 1'b0;
        model_cnt = '0;
        #3;
        check("rst_en", {26'd0, enables()}, 32'd0);
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_flags", {28'd0, busy_o, halted_o, err_o}, 32'd0);
        check("rst_instret", {27'd0, instret_o}, 32'd0);
        tick();
        rst_n_i = 1'b1;
        tick();
        check("idle_state", {29'd0, state_o}, 32'd0);

        // ALU stream: 3 cycles per instruction.
        resume();
        for (int i = 0; i < 3; i++) exec_inst(0, 0, 0, 1, 0, 0, 0, 0);
        check("instret_3", {27'd0, instret_o}, 32'd3);

        // Load with two wait cycles, then a store.
        exec_inst(1, 0, 0, 1, 2, 0, 0, 0);
        exec_inst(0, 1, 0, 1, 0, 0, 0, 0);

        // Store timeout and recovery.
        exec_inst(0, 1, 0, 1, -1, 0, 0, 1);
        resume();

        // Halt requested during EXEC, then during a valid FETCH.
        exec_inst(0, 0, 0, 1, 0, 0, 1, 1);
        resume();
        exec_inst(0, 0, 0, 0, 0, 1, 0, 1);
        resume();

        // Halt in FETCH with no instruction: pending flag takes one cycle to act.
        halt_req_i = 1'b1;
        tick();
        halt_req_i = 1'b0;
        #1;
        check("fetch_pend_state", {29'd0, state_o}, 32'd1);
        tick();
        check("fetch_halt_state", {29'd0, state_o}, 32'd5);
        resume();

        // Illegal opcode and load+store conflict.
        exec_inst(0, 0, 1, 1, 0, 0, 0, 0);
        resume();
        exec_inst(1, 1, 0, 1, 0, 0, 0, 0);
        resume();

        // Counter wrap.
        while (model_cnt != '1) exec_inst(0, 0, 0, 1, 0, 0, 0, 0);
        check("instret_max", {27'd0, instret_o}, 32'd31);
        exec_inst(0, 0, 0, 1, 0, 0, 0, 0);
        check("instret_wrap", {27'd0, instret_o}, 32'd0);

        // Async reset in the middle of a load.
        inst_load_i = 1'b1; inst_store_i = 1'b0; inst_illegal_i = 1'b0;
        iram_rd_valid_i = 1'b1;
        tick();
        iram_rd_valid_i = 1'b0;
        tick();
        #1;
        check("mem_before_rst", {31'd0, dram_rd_en_o}, 32'd1);
        #1;
        rst_n_i = 1'b0;
        #1;
        check("arst_en", {26'd0, enables()}, 32'd0);
        check("arst_state", {29'd0, state_o}, 32'd0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        sb_q.delete();
        model_cnt = '0;
        inst_load_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        check("post_rst_state", {29'd0, state_o}, 32'd0);
        check("post_rst_instret", {27'd0, instret_o}, 32'd0);
        check("post_rst_err", {30'd0, err_o}, 32'd0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
